// File: rtl/shift_word_receiver_if.sv
// Serial-in / word-out bus between a bit source, the word receiver and its consumer.
// The receiver takes the slave side; the driving environment takes the master side.
interface shift_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic             Clear;
  logic             SerialIn;
  logic             SerialValid;
  logic             Direction;
  logic             WordAck;
  logic [WIDTH-1:0] dataBus;
  logic             WordReady;
  logic             Overrun;
  logic [2:0]       BitCount;

  modport master (
    output Clear, SerialIn, SerialValid, Direction, WordAck,
    input  dataBus, WordReady, Overrun, BitCount
  );

  modport slave (
    input  Clear, SerialIn, SerialValid, Direction, WordAck,
    output dataBus, WordReady, Overrun, BitCount
  );
endinterface

// File: rtl/shift_word_receiver.sv
// Assembles WIDTH serial bits (MSB- or LSB-first) into a word and presents it
// through a one-entry output buffer with acknowledge and sticky overrun.
module shift_word_receiver #(
  parameter int WIDTH = 4
) (
  input logic                 clockPulse,
  input logic                 Reset,
  shift_word_receiver_if.slave bus
);

  typedef enum logic {IDLE, COLLECT} collState_t;
  typedef enum logic {EMPTY, FULL}   bufState_t;

  localparam logic [2:0] LastCount = 3'(WIDTH - 1);

  collState_t       collState, collNext;
  bufState_t        bufState, bufNext;
  logic [WIDTH-1:0] shReg, shNext;
  logic [WIDTH-1:0] dataReg, dataNext;
  logic [WIDTH-1:0] wordVal;
  logic [2:0]       cntReg, cntNext;
  logic             dirReg, dirNext, dirUse;
  logic             ovrReg, ovrNext;
  logic             wordDone;

  function automatic logic [WIDTH-1:0] shiftIn(input logic [WIDTH-1:0] cur,
                                               input logic lsbFirst,
                                               input logic bitIn);
    return lsbFirst ? {bitIn, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], bitIn};
  endfunction

  // The first bit of a word uses the live Direction; the rest use the latched copy.
  always_comb begin
    dirUse  = (collState == IDLE) ? bus.Direction : dirReg;
    wordVal = shiftIn(shReg, dirUse, bus.SerialIn);
  end

  always_comb begin
    collNext = collState;
    cntNext  = cntReg;
    shNext   = shReg;
    dirNext  = dirReg;
    wordDone = 1'b0;
    if (bus.Clear) begin
      collNext = IDLE;
      cntNext  = 3'd0;
      shNext   = '0;
    end else if (bus.SerialValid) begin
      if (cntReg == LastCount) begin
        wordDone = 1'b1;
        collNext = IDLE;
        cntNext  = 3'd0;
        shNext   = '0;
      end else begin
        collNext = COLLECT;
        cntNext  = cntReg + 3'd1;
        shNext   = wordVal;
        if (collState == IDLE) dirNext = bus.Direction;
      end
    end
  end

  always_ff @(posedge clockPulse or posedge Reset) begin
    if (Reset) begin
      collState <= IDLE;
      cntReg    <= 3'd0;
      shReg     <= '0;
      dirReg    <= 1'b0;
    end else begin
      collState <= collNext;
      cntReg    <= cntNext;
      shReg     <= shNext;
      dirReg    <= dirNext;
    end
  end

  // An ack on the completing edge frees the slot just in time for the new word.
  always_comb begin
    bufNext  = bufState;
    dataNext = dataReg;
    ovrNext  = ovrReg;
    if (bufState == EMPTY) begin
      if (wordDone) begin
        dataNext = wordVal;
        bufNext  = FULL;
      end
    end else begin
      if (wordDone && bus.WordAck) begin
        dataNext = wordVal;
      end else if (wordDone) begin
        ovrNext = 1'b1;
      end else if (bus.WordAck) begin
        bufNext = EMPTY;
      end
    end
  end

  always_ff @(posedge clockPulse or posedge Reset) begin
    if (Reset) begin
      bufState <= EMPTY;
      dataReg  <= '0;
      ovrReg   <= 1'b0;
    end else begin
      bufState <= bufNext;
      dataReg  <= dataNext;
      ovrReg   <= ovrNext;
    end
  end

  assign bus.dataBus   = dataReg;
  assign bus.WordReady = (bufState == FULL);
  assign bus.Overrun   = ovrReg;
  assign bus.BitCount  = cntReg;

endmodule

// File: tb/tb_shift_word_receiver.sv
// Table-driven bench for shift_word_receiver (WIDTH=4) with a word scoreboard.
module tb_shift_word_receiver;
  localparam int WIDTH = 4;

  logic clockPulse = 1'b0;
  logic Reset;

  shift_word_receiver_if #(.WIDTH(WIDTH)) bus();

  shift_word_receiver #(.WIDTH(WIDTH)) dut (
    .clockPulse(clockPulse),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #50 clockPulse = ~clockPulse;

  typedef struct {
    logic       clr, vld, din, dir, ack;
    logic [2:0] cnt;
    logic       rdy, ovr;
    logic [3:0] data;
    logic       push;
  } step_t;

  step_t      vec[$];
  logic [3:0] expQ[$];
  int         tests = 0;
  int         fails = 0;
  logic       prevRdy;
  logic [3:0] prevData;

  function automatic step_t S(input bit clr, input bit vld, input bit din, input bit dir,
                              input bit ack, input int cnt, input bit rdy, input bit ovr,
                              input bit [3:0] data, input bit push);
    step_t s;
    s.clr = clr; s.vld = vld; s.din = din; s.dir = dir; s.ack = ack;
    s.cnt = 3'(cnt); s.rdy = rdy; s.ovr = ovr; s.data = data; s.push = push;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit clr, input bit vld, input bit din, input bit dir, input bit ack);
    bus.Clear       = clr;
    bus.SerialValid = vld;
    bus.SerialIn    = din;
    bus.Direction   = dir;
    bus.WordAck     = ack;
  endtask

  task automatic scoreboard(input string tag);
    logic [3:0] e;
    if (bus.WordReady && (!prevRdy || bus.dataBus !== prevData)) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s word: unexpected word %0h, none expected", tag, bus.dataBus);
      end else begin
        e = expQ.pop_front();
        check({tag, " word"}, 32'(bus.dataBus), 32'(e));
      end
    end
    prevRdy  = bus.WordReady;
    prevData = bus.dataBus;
  endtask

  task automatic runStep(input step_t s, input string tag);
    @(negedge clockPulse);
    drive(s.clr, s.vld, s.din, s.dir, s.ack);
    if (s.push) expQ.push_back(s.data);
    @(posedge clockPulse);
    #1;
    check({tag, " BitCount"},  32'(bus.BitCount),  32'(s.cnt));
    check({tag, " WordReady"}, 32'(bus.WordReady), 32'(s.rdy));
    check({tag, " Overrun"},   32'(bus.Overrun),   32'(s.ovr));
    check({tag, " dataBus"},   32'(bus.dataBus),   32'(s.data));
    scoreboard(tag);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " dataBus"},   32'(bus.dataBus),   32'h0);
    check({tag, " WordReady"}, 32'(bus.WordReady), 32'h0);
    check({tag, " Overrun"},   32'(bus.Overrun),   32'h0);
    check({tag, " BitCount"},  32'(bus.BitCount),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int split;
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #20;
    checkAllZero("power-on reset");
    @(negedge clockPulse);
    Reset    = 1'b0;
    prevRdy  = 1'b0;
    prevData = 4'h0;

    // MSB-first 1,0,0,1; ack; ack while empty ignored
    vec.push_back(S(0,1,1,0,0, 1,0,0,4'b0000,0));
    vec.push_back(S(0,1,0,0,0, 2,0,0,4'b0000,0));
    vec.push_back(S(0,1,0,0,0, 3,0,0,4'b0000,0));
    vec.push_back(S(0,1,1,0,0, 0,1,0,4'b1001,1));
    vec.push_back(S(0,0,0,0,1, 0,0,0,4'b1001,0));
    vec.push_back(S(0,0,0,0,1, 0,0,0,4'b1001,0));
    // LSB-first 1,0,1,1 with Direction dropped after the first bit
    vec.push_back(S(0,1,1,1,0, 1,0,0,4'b1001,0));
    vec.push_back(S(0,1,0,0,0, 2,0,0,4'b1001,0));
    vec.push_back(S(0,1,1,0,0, 3,0,0,4'b1001,0));
    vec.push_back(S(0,1,1,0,0, 0,1,0,4'b1101,1));
    vec.push_back(S(0,0,0,0,1, 0,0,0,4'b1101,0));
    // 1001 then 0110 without ack: second word dropped, Overrun sticks
    vec.push_back(S(0,1,1,0,0, 1,0,0,4'b1101,0));
    vec.push_back(S(0,1,0,0,0, 2,0,0,4'b1101,0));
    vec.push_back(S(0,1,0,0,0, 3,0,0,4'b1101,0));
    vec.push_back(S(0,1,1,0,0, 0,1,0,4'b1001,1));
    vec.push_back(S(0,1,0,0,0, 1,1,0,4'b1001,0));
    vec.push_back(S(0,1,1,0,0, 2,1,0,4'b1001,0));
    vec.push_back(S(0,1,1,0,0, 3,1,0,4'b1001,0));
    vec.push_back(S(0,1,0,0,0, 0,1,1,4'b1001,0));
    vec.push_back(S(0,0,0,0,1, 0,0,1,4'b1001,0));
    vec.push_back(S(0,0,1,1,0, 0,0,1,4'b1001,0));
    split = vec.size();
    // After reset: 1001 pending, 0110 completes together with ack
    vec.push_back(S(0,1,1,0,0, 1,0,0,4'b0000,0));
    vec.push_back(S(0,1,0,0,0, 2,0,0,4'b0000,0));
    vec.push_back(S(0,1,0,0,0, 3,0,0,4'b0000,0));
    vec.push_back(S(0,1,1,0,0, 0,1,0,4'b1001,1));
    vec.push_back(S(0,1,0,0,0, 1,1,0,4'b1001,0));
    vec.push_back(S(0,1,1,0,0, 2,1,0,4'b1001,0));
    vec.push_back(S(0,1,1,0,0, 3,1,0,4'b1001,0));
    vec.push_back(S(0,1,0,0,1, 0,1,0,4'b0110,1));
    vec.push_back(S(0,0,0,0,1, 0,0,0,4'b0110,0));
    // Clear after two bits (with a discarded valid bit), then 1,1,0,0 with 3-cycle gaps
    vec.push_back(S(0,1,1,0,0, 1,0,0,4'b0110,0));
    vec.push_back(S(0,1,1,0,0, 2,0,0,4'b0110,0));
    vec.push_back(S(1,1,1,0,0, 0,0,0,4'b0110,0));
    vec.push_back(S(0,1,1,0,0, 1,0,0,4'b0110,0));
    for (int g = 0; g < 3; g++) vec.push_back(S(0,0,1,1,0, 1,0,0,4'b0110,0));
    vec.push_back(S(0,1,1,0,0, 2,0,0,4'b0110,0));
    for (int g = 0; g < 3; g++) vec.push_back(S(0,0,1,1,0, 2,0,0,4'b0110,0));
    vec.push_back(S(0,1,0,0,0, 3,0,0,4'b0110,0));
    for (int g = 0; g < 3; g++) vec.push_back(S(0,0,1,1,0, 3,0,0,4'b0110,0));
    vec.push_back(S(0,1,0,0,0, 0,1,0,4'b1100,1));

    for (int i = 0; i < split; i++) runStep(vec[i], $sformatf("step%0d", i));

    // Partial word then an asynchronous reset between edges
    runStep(S(0,1,1,0,0, 1,0,1,4'b1001,0), "prereset0");
    runStep(S(0,1,1,0,0, 2,0,1,4'b1001,0), "prereset1");
    @(negedge clockPulse);
    drive(0, 0, 0, 0, 0);
    #10 Reset = 1'b1;
    #5 checkAllZero("async reset");
    #10 Reset = 1'b0;
    prevRdy  = 1'b0;
    prevData = 4'h0;

    for (int i = split; i < vec.size(); i++) runStep(vec[i], $sformatf("step%0d", i));

    check("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_word_receiver.md
SHIFT_WORD_RECEIVER -- requirements
Module: shift_word_receiver

Interface
REQ-001 Parameter WIDTH, default 4: number of serial bits per assembled word; the legal range is 2..7.
REQ-002 clockPulse  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Clear  input  1  synchronous abort of the partial word in progress.
REQ-005 SerialIn  input  1  serial data bit, the ShiftOutput of the transmitting shift register.
REQ-006 SerialValid  input  1  SerialIn SHALL be sampled only on edges where this is 1.
REQ-007 Direction  input  1  bit order: 0 = MSB first (left-shifting source), 1 = LSB first (right-shifting source).
REQ-008 WordAck  input  1  consumer acknowledge of the presented word.
REQ-009 dataBus  output  WIDTH  last completed word, registered.
REQ-010 WordReady  output  1  dataBus holds an unacknowledged word.
REQ-011 Overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 BitCount  output  3  number of bits collected in the current partial word (0..WIDTH-1).

Function
REQ-013 The collector FSM SHALL have two states: IDLE (BitCount=0) and COLLECT (BitCount 1..WIDTH-1).
REQ-014 The output buffer FSM SHALL have two states: EMPTY (WordReady=0) and FULL (WordReady=1).
REQ-015 Priority on each edge SHALL be Reset > Clear > SerialValid.
REQ-016 Direction SHALL be latched on the first valid bit of a word (IDLE->COLLECT) and that latched value SHALL apply to the whole word; later changes in Direction are ignored until the next word.
REQ-017 For MSB-first order the internal shift register SHALL update as sh <= {sh[WIDTH-2:0], SerialIn}.
REQ-018 For LSB-first order the internal shift register SHALL update as sh <= {SerialIn, sh[WIDTH-1:1]}.
REQ-019 On a valid bit with BitCount<WIDTH-1, BitCount SHALL increment by 1 and the FSM SHALL be in COLLECT.
REQ-020 The WIDTH-th valid bit SHALL complete the word (shifted value including that bit), and BitCount SHALL return to 0 (IDLE) on the same edge.
REQ-021 Latency: on a completing edge with buffer EMPTY, dataBus and WordReady=1 SHALL be visible immediately after that same edge, with no extra cycle.
REQ-022 WordAck=1 while FULL SHALL set WordReady=0 on that edge, with dataBus left unchanged; WordAck while EMPTY SHALL be ignored.
REQ-023 Completion and WordAck on the same edge while FULL: the new word SHALL be loaded into dataBus, WordReady SHALL stay 1, and Overrun SHALL stay unchanged.
REQ-024 Completion while FULL without WordAck: the new word SHALL be discarded, dataBus SHALL be kept, and Overrun SHALL be set to 1.
REQ-025 Overrun SHALL clear only on Reset.
REQ-026 Collection SHALL continue while FULL; a full output buffer SHALL never stall the serial input.
REQ-027 Clear=1 SHALL set BitCount=0 and the shift register to 0, with dataBus, WordReady and Overrun unaffected; a SerialValid bit on the same edge SHALL be discarded.
REQ-028 SerialValid=0 SHALL hold all collector state.
REQ-029 Bits beyond BitCount SHALL NOT leak into a completed word; every word SHALL consist of exactly WIDTH sampled bits.

Reset
REQ-030 Reset=1 SHALL immediately force dataBus=0, WordReady=0, Overrun=0, BitCount=0, the internal shift register to 0 and the latched Direction to 0, regardless of the clock.
REQ-031 A Reset asserted mid-word SHALL discard the partial word, and the first valid bit after release SHALL start a new word.

Verification
REQ-032 The bench SHALL cover each of the following scenarios, with WIDTH=4 and a 100 ns clock period:
- Reset asserted asynchronously between edges -> all outputs 0 before the next clock edge.
- Direction=0, bits 1,0,0,1 on four consecutive valid edges -> dataBus=4'b1001 and WordReady=1 after the 4th edge; BitCount sequence 1,2,3,0.
- Direction=1, bits 1,0,1,1 -> dataBus=4'b1101; Direction toggled after the 1st bit -> result unchanged.
- Two words 1001 then 0110 with no WordAck -> dataBus=4'b1001, Overrun=1, WordReady=1.
- WordAck on the completing edge of word 0110 while 1001 is pending -> dataBus=4'b0110, WordReady=1, Overrun=0.
- Clear after 2 bits, then bits 1,1,0,0 -> dataBus=4'b1100 and no word produced by the first 2 bits; SerialValid gaps of 3 cycles inside a word -> same result.
